// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its
// next-address calculator.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_J,
    SEL_JR,
    SEL_END
  } nextSel_e;

  // Relative branch target: base + sext16(imm); the caller keeps the low bits.
  function automatic logic [31:0] brRelTarget(input logic [31:0] base,
                                              input logic [15:0] imm);
    return base + {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-address selection: end-of-run, jr, j, taken branch,
// then sequential, in that priority order.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int RESET_VEC = 0,
  parameter int END_ADDR  = 17,
  parameter bit BR_REL    = 1'b0
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              branch_i,
  input  logic              branchNe_i,
  input  logic              zero_i,
  input  logic              jump_i,
  input  logic              jumpReg_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       jtarget_i,
  input  logic [31:0]       jrAddr_i,
  output logic [ADDR_W-1:0] nextPc_o,
  output nextSel_e          sel_o
);

  localparam logic [ADDR_W-1:0] END_PC   = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);

  logic [ADDR_W-1:0] pcPlus1;
  logic [31:0]       relTarget;
  logic [ADDR_W-1:0] brTarget;
  logic              brTaken;
  logic              unusedBits;

  assign pcPlus1   = pc_i + ADDR_W'(1);
  assign relTarget = brRelTarget(32'(pcPlus1), imm_i);
  assign brTarget  = BR_REL ? relTarget[ADDR_W-1:0] : imm_i[ADDR_W-1:0];
  assign brTaken   = branch_i & (zero_i ^ branchNe_i);

  // Targets are deliberately truncated to the PC width; the high bits are dropped.
  assign unusedBits = ^{relTarget[31:ADDR_W], jrAddr_i[31:ADDR_W],
                        jtarget_i[25:ADDR_W], imm_i[15:ADDR_W]};

  always_comb begin
    sel_o    = SEL_SEQ;
    nextPc_o = pcPlus1;
    if (pc_i == END_PC) begin
      sel_o    = SEL_END;
      nextPc_o = RESET_PC;
    end else if (jumpReg_i) begin
      sel_o    = SEL_JR;
      nextPc_o = jrAddr_i[ADDR_W-1:0];
    end else if (jump_i) begin
      sel_o    = SEL_J;
      nextPc_o = jtarget_i[ADDR_W-1:0];
    end else if (brTaken) begin
      sel_o    = SEL_BR;
      nextPc_o = brTarget;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE run control, PC register,
// stall handling and a saturating retired-instruction counter.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int RESET_VEC = 0,
  parameter int END_ADDR  = 17,
  parameter bit BR_REL    = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              branchNe_i,
  input  logic              zero_i,
  input  logic              jump_i,
  input  logic              jumpReg_i,
  input  logic [15:0]       imm_i,
  input  logic [25:0]       jtarget_i,
  input  logic [31:0]       jrAddr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pcPlus1_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              donePulse_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              done_q, done_d;
  logic              donePulse_q, donePulse_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] nextPc;
  nextSel_e          nextSel;

  pc_next_calc #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(RESET_VEC),
    .END_ADDR (END_ADDR),
    .BR_REL   (BR_REL)
  ) u_next (
    .pc_i      (pc_q),
    .branch_i  (branch_i),
    .branchNe_i(branchNe_i),
    .zero_i    (zero_i),
    .jump_i    (jump_i),
    .jumpReg_i (jumpReg_i),
    .imm_i     (imm_i),
    .jtarget_i (jtarget_i),
    .jrAddr_i  (jrAddr_i),
    .nextPc_o  (nextPc),
    .sel_o     (nextSel)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    done_d      = done_q;
    donePulse_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        pc_d = RESET_PC;
        if (start_i) begin
          state_d   = RUN;
          retired_d = '0;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        // A stall freezes everything, including the end-of-run transition.
        if (!stall_i) begin
          pc_d      = nextPc;
          retired_d = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
          if (nextSel == SEL_END) begin
            state_d     = DONE;
            done_d      = 1'b1;
            donePulse_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      retired_q   <= '0;
      done_q      <= 1'b0;
      donePulse_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      retired_q   <= retired_d;
      done_q      <= done_d;
      donePulse_q <= donePulse_d;
      busy_q      <= busy_d;
    end
  end

  assign pc_o        = pc_q;
  assign pcPlus1_o   = pc_q + ADDR_W'(1);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign donePulse_o = donePulse_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: absolute-branch and relative-branch instances share
// one stimulus stream and are checked against a behavioural model every cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, branch, branchNe, zero, jump, jumpReg;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] jrAddr;

  logic [7:0]  pc0, pcp0, pc1, pcp1;
  logic        busy0, done0, pulse0, busy1, done1, pulse1;
  logic [15:0] ret0, ret1;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  // Model state per instance: 0 idle, 1 run, 2 done.
  int mState[2], mPc[2], mRet[2], mDone[2], mPulse[2];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(0), .END_ADDR(17), .BR_REL(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stall_i(stall), .branch_i(branch),
    .branchNe_i(branchNe), .zero_i(zero), .jump_i(jump), .jumpReg_i(jumpReg),
    .imm_i(imm), .jtarget_i(jtarget), .jrAddr_i(jrAddr), .pc_o(pc0), .pcPlus1_o(pcp0),
    .busy_o(busy0), .done_o(done0), .donePulse_o(pulse0), .retired_o(ret0));

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(0), .END_ADDR(17), .BR_REL(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stall_i(stall), .branch_i(branch),
    .branchNe_i(branchNe), .zero_i(zero), .jump_i(jump), .jumpReg_i(jumpReg),
    .imm_i(imm), .jtarget_i(jtarget), .jrAddr_i(jrAddr), .pc_o(pc1), .pcPlus1_o(pcp1),
    .busy_o(busy1), .done_o(done1), .donePulse_o(pulse1), .retired_o(ret1));

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model written from the run rules: end address wins, then jr, j, taken branch, pc+1.
  always @(posedge clk or negedge rst_n) begin
    int np, nr, ns, nd, npl, s;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        ns = 0; np = 0; nr = 0; nd = 0; npl = 0;
      end else begin
        ns = mState[i]; np = mPc[i]; nr = mRet[i]; nd = mDone[i]; npl = 0;
        if (mState[i] != 1) begin
          np = 0;
          if (start) begin ns = 1; nr = 0; nd = 0; end
        end else if (!stall) begin
          nr = (mRet[i] == 65535) ? 65535 : mRet[i] + 1;
          if (mPc[i] == 17) begin
            np = 0; ns = 2; nd = 1; npl = 1;
          end else if (jumpReg) begin
            np = int'(jrAddr % 256);
          end else if (jump) begin
            np = int'(jtarget % 256);
          end else if (branch && (zero != branchNe)) begin
            if (i == 1) begin
              s = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
              np = ((mPc[i] + 1 + s) % 256 + 256) % 256;
            end else begin
              np = int'(imm % 256);
            end
          end else begin
            np = (mPc[i] + 1) % 256;
          end
        end
      end
      mState[i] <= ns; mPc[i] <= np; mRet[i] <= nr; mDone[i] <= nd; mPulse[i] <= npl;
    end
  end

  task automatic compareDut(input int i, input logic [7:0] pcV, input logic [7:0] pcpV,
                            input logic busyV, input logic doneV, input logic pulseV,
                            input logic [15:0] retV);
    checkOutput($sformatf("dut%0d.pc", i), 32'(pcV), 32'(mPc[i]));
    checkOutput($sformatf("dut%0d.pc_plus1", i), 32'(pcpV), 32'((mPc[i] + 1) % 256));
    checkOutput($sformatf("dut%0d.busy", i), 32'(busyV), 32'(mState[i] == 1));
    checkOutput($sformatf("dut%0d.done", i), 32'(doneV), 32'(mDone[i]));
    checkOutput($sformatf("dut%0d.done_pulse", i), 32'(pulseV), 32'(mPulse[i]));
    checkOutput($sformatf("dut%0d.retired", i), 32'(retV), 32'(mRet[i]));
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      compareDut(0, pc0, pcp0, busy0, done0, pulse0, ret0);
      compareDut(1, pc1, pcp1, busy1, done1, pulse1, ret1);
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic st, input logic stl, input logic br,
                               input logic bne, input logic z, input logic j,
                               input logic jr, input logic [15:0] im,
                               input logic [25:0] jt, input logic [31:0] jra);
    start = st; stall = stl; branch = br; branchNe = bne; zero = z;
    jump = j; jumpReg = jr; imm = im; jtarget = jt; jrAddr = jra;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic doJump(input logic [25:0] t);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'h0, t, 32'h0);
  endtask

  task automatic doBranch(input logic bne, input logic z, input logic [15:0] im);
    applyStimulus(0, 0, 1, bne, z, 0, 0, im, 26'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; stall = 0; branch = 0; branchNe = 0; zero = 0;
    jump = 0; jumpReg = 0; imm = '0; jtarget = '0; jrAddr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.pc", 32'(pc0), 32'd0);
    checkOutput("reset.pc_plus1", 32'(pcp0), 32'd1);
    checkOutput("reset.busy", 32'(busy0), 32'd0);
    checkOutput("reset.done", 32'(done0), 32'd0);
    checkOutput("reset.retired", 32'(ret0), 32'd0);
    checkEn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idleCycles(1);
    checkOutput("idle.busy", 32'(busy0), 32'd0);

    // Straight-line run to the end address.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    checkOutput("start.busy", 32'(busy0), 32'd1);
    checkOutput("start.pc", 32'(pc0), 32'd0);
    idleCycles(17);
    checkOutput("run.pc17", 32'(pc0), 32'd17);
    checkOutput("run.retired17", 32'(ret0), 32'd17);
    idleCycles(1);
    checkOutput("end.pc", 32'(pc0), 32'd0);
    checkOutput("end.done", 32'(done0), 32'd1);
    checkOutput("end.pulse", 32'(pulse0), 32'd1);
    checkOutput("end.retired", 32'(ret0), 32'd18);
    idleCycles(1);
    checkOutput("end.pulse_fall", 32'(pulse0), 32'd0);
    checkOutput("end.done_sticky", 32'(done0), 32'd1);

    // Restart from DONE, then branch tests.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    checkOutput("restart.retired", 32'(ret0), 32'd0);
    checkOutput("restart.done", 32'(done0), 32'd0);
    idleCycles(3);
    doBranch(0, 1, 16'd10);
    checkOutput("beq.abs", 32'(pc0), 32'd10);
    checkOutput("beq.rel", 32'(pc1), 32'd14);
    doJump(26'd3);
    doBranch(1, 1, 16'd10);
    checkOutput("bne.nt.abs", 32'(pc0), 32'd4);
    checkOutput("bne.nt.rel", 32'(pc1), 32'd4);
    doJump(26'd3);
    doBranch(1, 0, 16'd10);
    checkOutput("bne.t.abs", 32'(pc0), 32'd10);
    checkOutput("bne.t.rel", 32'(pc1), 32'd14);
    doJump(26'd5);
    doBranch(0, 1, 16'hFFFD);
    checkOutput("rel.neg", 32'(pc1), 32'd3);
    checkOutput("abs.trunc", 32'(pc0), 32'd253);
    doJump(26'd255);
    idleCycles(1);
    checkOutput("wrap.pc", 32'(pc1), 32'd0);

    // Priority: jr beats j beats branch; end address beats everything.
    applyStimulus(0, 0, 1, 0, 1, 1, 1, 16'h50, 26'h40, 32'h123);
    checkOutput("prio.jr", 32'(pc0), 32'h23);
    doJump(26'd17);
    doJump(26'd5);
    checkOutput("prio.end.pc", 32'(pc0), 32'd0);
    checkOutput("prio.end.done", 32'(done0), 32'd1);

    // Stall at the end address.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    doJump(26'd17);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 16'h0, 26'd5, 32'h0);
      checkOutput("stall.pc", 32'(pc0), 32'd17);
      checkOutput("stall.done", 32'(done0), 32'd0);
      checkOutput("stall.retired", 32'(ret0), 32'd1);
    end
    idleCycles(1);
    checkOutput("unstall.done", 32'(done0), 32'd1);
    checkOutput("unstall.retired", 32'(ret0), 32'd2);

    // Asynchronous reset in the middle of a run.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    doJump(26'd9);
    checkOutput("midrun.pc9", 32'(pc0), 32'd9);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async.pc", 32'(pc0), 32'd0);
    checkOutput("async.busy", 32'(busy0), 32'd0);
    checkOutput("async.retired", 32'(ret0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // start with stall in IDLE still enters RUN; start during RUN is ignored.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    checkOutput("startstall.busy", 32'(busy0), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    checkOutput("runstart.pc", 32'(pc0), 32'd1);
    checkOutput("runstart.retired", 32'(ret0), 32'd1);
    idleCycles(2);

    @(negedge clk);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS single-cycle CPU, replacing the fixed 8-bit PC. It holds the fetch address and selects the next address from sequential, conditional-branch (absolute or PC-relative), jump and register-jump targets. It adds a start/done run handshake, stall support, a configurable end address and a retired-instruction counter. It sits between the control unit/ALU and instruction memory.

## Interface
- ADDR_W, 8: PC width in words.
- RESET_VEC, 0: PC value after reset, in IDLE, and after completion.
- END_ADDR, 17: address whose execution ends a run.
- BR_REL, 0: branch mode. 0 = absolute target `imm[ADDR_W-1:0]`; 1 = `pc + 1 + sext(imm)`.
- CNT_W, 16: retired-counter width.

- Clk  in  1  clock, rising edge.
- Clr  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- stall  in  1  hold PC and counter this cycle.
- branch  in  1  conditional-branch instruction.
- branch_ne  in  1  0 = beq, 1 = bne (instruction bit 26).
- zero  in  1  ALU zero flag.
- jump  in  1  j/jal instruction.
- jump_reg  in  1  jr instruction.
- imm  in  16  branch immediate.
- jtarget  in  26  jump target field.
- jr_addr  in  32  register value for jr.
- pc  out  ADDR_W  current fetch address.
- pc_plus1  out  ADDR_W  pc+1, used as the link value for jal.
- busy  out  1  high in RUN.
- done  out  1  sticky completion flag.
- done_pulse  out  1  one-cycle completion strobe.
- retired  out  CNT_W  count of instructions advanced this run.

## Operation
- The state machine has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:** pc = RESET_VEC. When start=1, go to RUN, clear retired and clear done. pc is unchanged on the transition.
- **RUN:** on each edge where stall=0, pc takes the next address by this priority:
  1. **End of run:** pc==END_ADDR. pc becomes RESET_VEC, state becomes DONE, done=1 and done_pulse=1. Control inputs are ignored.
  2. **jump_reg:** pc becomes `jr_addr[ADDR_W-1:0]`.
  3. **jump:** pc becomes `jtarget[ADDR_W-1:0]`.
  4. **Branch taken:** the condition is `branch & (zero ^ branch_ne)`. pc becomes the branch target selected by BR_REL.
  5. **Default:** pc becomes pc+1.
- **retired:** increments on every non-stalled RUN edge, including the end-of-run edge. It saturates at all-ones.
- **Stall:** stall=1 holds pc and retired and blocks the end-of-run transition. pc==END_ADDR with stall=1 therefore waits.
- **DONE:** pc = RESET_VEC, done stays 1, retired is held. start=1 goes to RUN, clears done and clears retired.
- start is ignored while in RUN.
- **Arithmetic:** all PC arithmetic is modulo 2^ADDR_W. pc+1 at all-ones wraps to 0. Targets wider than ADDR_W are truncated to the low bits. sext means a 16-bit sign extension, then truncation.
- **Reset mid-run:** Clr=0 at any time forces IDLE asynchronously, with pc=RESET_VEC, done=0, done_pulse=0, retired=0.
- **Reset values of outputs:** pc=RESET_VEC, pc_plus1=RESET_VEC+1, busy=0, done=0, done_pulse=0, retired=0.

## Timing
- All outputs except pc_plus1 are registered. pc_plus1 is combinational from pc.
- Control inputs are sampled on the rising edge. The new pc is visible after that edge, giving single-cycle latency.
- The first fetch after start is RESET_VEC, in the first RUN cycle.
- done and done_pulse rise on the same edge that pc returns to RESET_VEC. done_pulse falls one cycle later.
- If start and stall are both high in IDLE, the FSM still enters RUN. stall affects only RUN.

## Structure
- Shared package `pc_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the next-PC select enum (SEQ, BR, J, JR, END);
  - a sign-extend/truncate function for the branch target.
- One sub-module, `pc_next_calc`, is purely combinational. It takes pc and the control inputs and returns the next address and the select code.
- The FSM, pc register and counter live in `pc_sequencer`.

## Test plan
- **Reset to run:** Clr low, then high, then start pulse, no branches, ADDR_W=8, END_ADDR=17. Expect pc 0,1,…,17, then 0; done=1; done_pulse high exactly 1 cycle; retired=18.
- **beq and bne, BR_REL=0:**
  - At pc=3 with branch=1, branch_ne=0, zero=1, imm=10: pc becomes 10.
  - Same but branch_ne=1: pc becomes 4.
  - bne with zero=0: pc becomes 10.
- **Relative branch and wrap, BR_REL=1:**
  - pc=5, imm=0xFFFD (−3): pc becomes 3.
  - pc=255 with no control: pc becomes 0.
- **Priority:** jump_reg=1, jump=1 and a taken branch all asserted together, jr_addr=0x123 → pc=0x23. pc==END_ADDR with jump=1 → pc=RESET_VEC and done=1.
- **Stall:** stall held 3 cycles at pc=17 → pc stays 17, done stays 0, retired frozen. stall released → done rises.
- **Reset mid-run:** Clr low at pc=9 → pc=0, busy=0, retired=0 immediately, without waiting for a clock edge. start during RUN is ignored; start in DONE restarts with retired cleared.
